// File: rtl/hvac_zone_scheduler.sv
// Four-zone HVAC plant scheduler: round-robin grant, dwell/max/dead-time FSM.
// clk/rst, zone_temp[20], setpoint[5], zone_en[4] -> heating, cooling, damper[4], busy.
module hvac_zone_scheduler #(
  parameter int DWELL_CYCLES = 8,
  parameter int MAX_CYCLES   = 32,
  parameter int DEAD_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] zone_temp,
  input  logic [4:0]  setpoint,
  input  logic [3:0]  zone_en,
  output logic        heating,
  output logic        cooling,
  output logic [3:0]  damper,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    DEAD
  } state_t;

  localparam logic [5:0] DWELL_L = 6'(DWELL_CYCLES - 1);
  localparam logic [5:0] MAX_L   = 6'(MAX_CYCLES - 1);
  localparam logic [5:0] DEAD_L  = 6'(DEAD_CYCLES - 1);

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] zone;
  logic       mode;
  logic [5:0] cnt;

  logic [5:0] t6 [4];
  logic [5:0] sp6;
  logic [3:0] heat_req;
  logic [3:0] cool_req;
  logic [3:0] req;

  // Six-bit compares so temp+2 and setpoint+2 never wrap.
  always_comb begin
    sp6      = {1'b0, setpoint};
    heat_req = '0;
    cool_req = '0;
    for (int i = 0; i < 4; i++) begin
      t6[i]       = {1'b0, zone_temp[5*i +: 5]};
      heat_req[i] = zone_en[i] & ((t6[i] + 6'd2) <= sp6);
      cool_req[i] = zone_en[i] & (t6[i] >= (sp6 + 6'd2));
    end
    req = heat_req | cool_req;
  end

  logic       hit;
  logic [1:0] win;
  logic [1:0] idx;

  // Rotating priority starting at ptr.
  always_comb begin
    hit = 1'b0;
    win = ptr;
    idx = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!hit && req[idx]) begin
        hit = 1'b1;
        win = idx;
      end
    end
  end

  logic [5:0] cur;
  logic       sat;
  logic       leave;

  always_comb begin
    cur   = t6[zone];
    sat   = mode ? (cur >= sp6) : (cur <= sp6);
    leave = !zone_en[zone]
          || ((cnt >= DWELL_L) && sat)
          || (cnt == MAX_L);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 2'd0;
      zone    <= 2'd0;
      mode    <= 1'b0;
      cnt     <= 6'd0;
      heating <= 1'b0;
      cooling <= 1'b0;
      damper  <= 4'd0;
      busy    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hit) begin
            state   <= SERVE;
            zone    <= win;
            mode    <= heat_req[win];
            cnt     <= 6'd0;
            heating <= heat_req[win];
            cooling <= !heat_req[win];
            damper  <= 4'b0001 << win;
            busy    <= 1'b1;
          end
        end
        SERVE: begin
          if (leave) begin
            state   <= DEAD;
            ptr     <= zone + 2'd1;
            cnt     <= 6'd0;
            heating <= 1'b0;
            cooling <= 1'b0;
            damper  <= 4'd0;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        DEAD: begin
          if (cnt == DEAD_L) begin
            state <= IDLE;
            cnt   <= 6'd0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= 6'd0;
          heating <= 1'b0;
          cooling <= 1'b0;
          damper  <= 4'd0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hvac_zone_scheduler.sv
// Bench for hvac_zone_scheduler: expected grants queued at stimulus,
// a monitor measures each SERVE/DEAD/IDLE span and compares.
module tb_hvac_zone_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] zone_temp;
  logic [4:0]  setpoint;
  logic [3:0]  zone_en;
  logic        heating;
  logic        cooling;
  logic [3:0]  damper;
  logic        busy;

  hvac_zone_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .zone_temp (zone_temp),
    .setpoint  (setpoint),
    .zone_en   (zone_en),
    .heating   (heating),
    .cooling   (cooling),
    .damper    (damper),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    int zone;
    int heat;
    int slen;
    int dlen;
    int idle;
  } exp_t;

  exp_t q[$];

  task automatic push(input int z, input int h, input int s,
                      input int d, input int i);
    exp_t e;
    e.zone = z;
    e.heat = h;
    e.slen = s;
    e.dlen = d;
    e.idle = i;
    q.push_back(e);
  endtask

  task automatic set_temps(input logic [4:0] t0, input logic [4:0] t1,
                           input logic [4:0] t2, input logic [4:0] t3);
    zone_temp = {t3, t2, t1, t0};
  endtask

  bit         in_serve = 0;
  bit         in_dead  = 0;
  logic [3:0] s_damp   = '0;
  int         s_heat   = 0;
  int         s_len    = 0;
  int         d_len    = 0;
  int         idle_cnt = 0;
  int         g_idle   = 0;
  int         serves_done = 0;

  task automatic close_rec();
    exp_t e;
    int   z;
    z = -1;
    for (int i = 0; i < 4; i++)
      if (s_damp[i]) z = i;
    if (q.size() == 0) begin
      check("unexpected_grant", 1, 0);
    end else begin
      e = q.pop_front();
      check("grant_zone", z, e.zone);
      check("grant_heat", s_heat, e.heat);
      check("serve_len", s_len, e.slen);
      check("dead_len", d_len, e.dlen);
      if (e.idle >= 0) check("idle_gap", g_idle, e.idle);
    end
    in_serve = 0;
    in_dead  = 0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      in_serve = 0;
      in_dead  = 0;
      idle_cnt = 0;
    end else begin
      check("excl", int'(heating & cooling), 0);
      if (damper != 4'd0) begin
        if (!in_serve) begin
          if (in_dead) close_rec();
          in_serve = 1;
          s_damp   = damper;
          s_heat   = int'(heating);
          s_len    = 0;
          d_len    = 0;
          g_idle   = idle_cnt;
          idle_cnt = 0;
          check("onehot", $countones(damper), 1);
        end
        check("damper_hold", int'(damper), int'(s_damp));
        check("mode_hold", int'(heating), s_heat);
        check("plant_on", int'(heating | cooling), 1);
        s_len++;
      end else if (busy) begin
        if (in_serve) begin
          in_serve = 0;
          in_dead  = 1;
          serves_done++;
        end
        check("dead_off", int'(heating | cooling), 0);
        d_len++;
      end else begin
        if (in_serve) serves_done++;
        if (in_serve || in_dead) close_rec();
        check("idle_off", int'(heating | cooling), 0);
        idle_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    while (damper == 4'd0 && n < 50) begin
      tick();
      n++;
    end
    if (damper == 4'd0) check(tag, 0, 1);
  endtask

  task automatic wait_serves(input int k, input string tag);
    int tgt = serves_done + k;
    int n = 0;
    while (serves_done < tgt && n < 400) begin
      tick();
      n++;
    end
    if (serves_done < tgt) check(tag, serves_done, tgt);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    if (busy) check(tag, 1, 0);
    @(negedge clk);
    #1;
  endtask

  initial begin
    setpoint = 5'd20;
    zone_en  = 4'hf;
    set_temps(20, 20, 20, 20);
    repeat (2) tick();
    check("rst_heating", int'(heating), 0);
    check("rst_cooling", int'(cooling), 0);
    check("rst_damper", int'(damper), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;

    // single heat demand, satisfied early, still holds the dwell
    set_temps(16, 20, 20, 20);
    push(0, 1, 8, 4, -1);
    tick();
    check("lat_heating", int'(heating), 1);
    check("lat_cooling", int'(cooling), 0);
    check("lat_damper", int'(damper), 1);
    check("lat_busy", int'(busy), 1);
    repeat (3) tick();
    set_temps(20, 20, 20, 20);
    wait_idle("single_timeout");

    // mode changeover, ptr now 1 so the cool zone goes first
    set_temps(16, 24, 20, 20);
    push(1, 0, 32, 4, -1);
    push(0, 1, 32, 4, 1);
    wait_serves(2, "change_timeout");
    set_temps(20, 20, 20, 20);
    wait_idle("change_idle");

    // round robin between zones 1 and 3
    set_temps(20, 25, 20, 25);
    push(1, 0, 32, 4, -1);
    push(3, 0, 32, 4, 1);
    push(1, 0, 32, 4, 1);
    wait_serves(3, "rr_timeout");
    set_temps(20, 20, 20, 20);
    wait_idle("rr_idle");

    // disable mid-service at cnt 2
    set_temps(20, 20, 16, 20);
    push(2, 1, 3, 4, -1);
    wait_grant("dis_grant");
    check("dis_damper_on", int'(damper), 4);
    repeat (2) tick();
    zone_en = 4'b1011;
    tick();
    check("dis_busy", int'(busy), 1);
    check("dis_damper_off", int'(damper), 0);
    zone_en = 4'hf;
    set_temps(16, 20, 20, 25);
    push(3, 0, 8, 4, 1);
    wait_grant("ptr3_grant");
    check("ptr3_damper", int'(damper), 8);
    set_temps(20, 20, 20, 20);
    wait_idle("ptr3_idle");

    // compare boundaries
    set_temps(18, 20, 20, 20);
    push(0, 1, 8, 4, -1);
    tick();
    check("heat18_damper", int'(damper), 1);
    check("heat18_heating", int'(heating), 1);
    set_temps(20, 20, 20, 20);
    wait_idle("heat18_idle");
    set_temps(19, 20, 20, 20);
    repeat (3) tick();
    check("none19_busy", int'(busy), 0);
    set_temps(21, 20, 20, 20);
    repeat (3) tick();
    check("none21_busy", int'(busy), 0);
    set_temps(22, 20, 20, 20);
    push(0, 0, 8, 4, -1);
    tick();
    check("cool22_cooling", int'(cooling), 1);
    check("cool22_damper", int'(damper), 1);
    set_temps(20, 20, 20, 20);
    wait_idle("cool22_idle");
    setpoint = 5'd1;
    set_temps(0, 0, 0, 0);
    repeat (3) tick();
    check("sp1_busy", int'(busy), 0);
    setpoint = 5'd30;
    set_temps(31, 31, 31, 31);
    repeat (3) tick();
    check("sp30_busy", int'(busy), 0);
    setpoint = 5'd2;
    zone_en  = 4'b0010;
    set_temps(0, 0, 0, 0);
    push(1, 1, 8, 4, -1);
    tick();
    check("sp2_heating", int'(heating), 1);
    check("sp2_damper", int'(damper), 2);
    set_temps(0, 2, 0, 0);
    wait_idle("sp2_idle");

    // reset in the middle of a zone 2 heat service
    setpoint = 5'd20;
    set_temps(20, 20, 16, 20);
    zone_en = 4'hf;
    wait_grant("rst_grant");
    check("rst_srv_damper", int'(damper), 4);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_heating", int'(heating), 0);
    check("arst_damper", int'(damper), 0);
    check("arst_busy", int'(busy), 0);
    tick();
    rst = 1'b0;
    set_temps(16, 20, 20, 25);
    push(0, 1, 8, 4, -1);
    tick();
    check("ptr0_damper", int'(damper), 1);
    set_temps(20, 20, 20, 20);
    wait_idle("ptr0_idle");

    repeat (3) tick();
    check("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hvac_zone_scheduler.md
# hvac_zone_scheduler

Shares one heating/cooling plant (the `heating`/`cooling` pair driven by the air-conditioning block) between four temperature zones. Each zone raises a heat or cool demand from its 5-bit temperature against a common setpoint. A round-robin arbiter grants the plant to one zone at a time, opening that zone's damper. The block enforces a minimum dwell, a maximum service time and an all-off dead time between grants, so heating and cooling are never asserted together.

## Interface
- `DWELL_CYCLES`, 8: minimum SERVE length in cycles (≥1).
- `MAX_CYCLES`, 32: maximum SERVE length in cycles (≥ DWELL_CYCLES).
- `DEAD_CYCLES`, 4: plant-off cycles after every SERVE (≥1).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `zone_temp` in 20: zone i temperature in `[5i+4:5i]`, unsigned °C, 0–31.
- `setpoint` in 5: common target temperature, unsigned.
- `zone_en` in 4: per-zone enable. A disabled zone never requests.
- `heating` out 1: plant heating on.
- `cooling` out 1: plant cooling on.
- `damper` out 4: one-hot open damper of the served zone, 0 otherwise.
- `busy` out 1: high when state ≠ IDLE.

## Operation
- Per-zone demand uses 6-bit zero-extended compares, with no wrap:
  - heat_req[i] = zone_en[i] & (temp_i + 2 ≤ setpoint).
  - cool_req[i] = zone_en[i] & (temp_i ≥ setpoint + 2).
  - req[i] = heat_req[i] | cool_req[i].
  - heat_req and cool_req are mutually exclusive by construction.
  - setpoint < 2 gives no heat demand. setpoint > 29 gives no cool demand.
- State machine: IDLE, SERVE, DEAD. Registers: `ptr` (2 bits), `zone` (2 bits), `mode` (heat/cool), `cnt` (6 bits, counts to MAX_CYCLES−1).
- IDLE:
  - Plant off, dampers closed.
  - Search req in order ptr, ptr+1, … mod 4. The first hit wins.
  - On a hit: latch zone, mode = heat if heat_req[zone] else cool, cnt ← 0, go to SERVE.
  - With no hit, stay in IDLE.
- SERVE:
  - heating = (mode==heat), cooling = (mode==cool), damper = 1<<zone.
  - cnt increments every cycle.
  - The zone is satisfied when, in heat mode, temp ≥ setpoint, or, in cool mode, temp ≤ setpoint. Both use the live setpoint and temperature.
  - Exit to DEAD at the edge where any of these holds:
    - (a) zone_en[zone]==0, regardless of dwell.
    - (b) cnt ≥ DWELL_CYCLES−1 and the zone is satisfied.
    - (c) cnt == MAX_CYCLES−1.
  - On exit: ptr ← zone+1 mod 4, cnt ← 0.
- DEAD:
  - Plant off, dampers closed.
  - Leave for IDLE after DEAD_CYCLES cycles.
  - Demands are ignored during DEAD.
- Invariants:
  - heating & cooling is never 1.
  - damper is nonzero only in SERVE.
  - The plant never changes mode or zone without passing through DEAD.

## Timing
- Reset values: state IDLE, ptr 0, zone 0, cnt 0. heating = cooling = busy = 0, damper = 0. Outputs fall asynchronously on rst assertion, including mid-SERVE.
- Outputs are Moore-decoded from registered state, with no combinational path from inputs.
- Grant latency: a request sampled at edge E in IDLE causes heating/cooling/damper/busy to go high immediately after E.
- SERVE length L satisfies min(DWELL_CYCLES, exit point) ≤ L ≤ MAX_CYCLES. A disable exit may cut it as short as 1 cycle.
- DEAD lasts exactly DEAD_CYCLES cycles. It is followed by at least one IDLE cycle before the next SERVE.
- Grant-to-grant minimum spacing is SERVE + DEAD_CYCLES + 1 cycles.
- Simultaneous requests are resolved by ptr only. Mode is taken from the winner.
- Setpoint or temperature changes mid-SERVE affect only the exit check, never the latched mode.

## Test plan
- Reset during SERVE (zone 2 heating): assert rst mid-cycle → heating, damper and busy go to 0 at once. After release the block is in IDLE with ptr 0.
- Single heat demand: setpoint 20, zone0 temp 16, others 20. → Next edge: heating=1, damper=0001. Raise temp to 20 after 3 cycles → SERVE still lasts exactly 8 cycles, then 4 DEAD cycles.
- Round-robin: zones 1 and 3 both at 25 (cool), setpoint 20, held. → Grants in order zone1, zone3, zone1…, each for 32 cycles. cooling=1 and heating=0 throughout SERVE.
- Mode changeover: zone0 heat-demand (16) and zone1 cool-demand (24), setpoint 20. → heating SERVE, then 4 cycles with both off, then cooling SERVE. Never both high on any cycle.
- Boundary compares: setpoint 20, temp 18 → heat request. Temp 19 or 21 → no request. Temp 22 → cool request. setpoint 1, temp 0 → no request.
- Disable mid-service: zone2 serving at cnt 2, zone_en[2]←0 → DEAD on the next edge. ptr becomes 3.
